vote_collector: RTL and testbench
=================================

# vote_collector

Front-end for the five-input majority stage. Conditions five asynchronous voter pushbuttons, runs a timed voting session, and latches at most one "yes" per voter. It then presents the final ballot on A–E, the majority stage's inputs, with a one-cycle valid strobe and a yes-count. The ballot is held stable between sessions, so the downstream combinational vote output is glitch-free.

## Interface
Parameters:
- DEB_CYCLES, 16, consecutive stable cycles required before a conditioned button level changes (≥2)
- WINDOW_CYCLES, 1000, length of the voting window in clk cycles (≥1)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  synchronous pulse; opens a session from IDLE or HOLD
- vote_btn  in  5  raw asynchronous voter buttons, 1 = pressed; bit 0 → A … bit 4 → E
- A, B, C, D, E  out  1 each  latched ballot bits, 1 = yes; drive the majority stage
- voted  out  5  per-voter "has voted" flags, same bit order
- yes_cnt  out  3  population count of the ballot (0–5)
- busy  out  1  high while the session is OPEN
- valid  out  1  one-cycle pulse when the ballot is final

## Operation
- Input path per button:
  - 2-flop synchronizer.
  - Debouncer (when compiled in).
  - Rising-edge detector. A press is a 0→1 transition of the conditioned level.
- FSM states:
  - IDLE → OPEN on start. Entering OPEN clears the ballot and voted, and loads the window counter with WINDOW_CYCLES.
  - OPEN: counter decrements every cycle. A press edge on voter i with voted[i]=0 sets ballot bit i and voted[i]. Later presses by the same voter are ignored.
  - OPEN → DONE when the counter reaches 1 and is being decremented, or when voted becomes 5'b11111 (early close), whichever comes first.
  - DONE: valid=1 for exactly one cycle, then → HOLD.
  - HOLD: ballot, voted and yes_cnt are frozen. start → OPEN (clears and reloads as above).
- start is ignored in OPEN and DONE.
- Press edges outside OPEN are discarded. A button held down across start does not vote until it is released and pressed again.
- yes_cnt is registered and updates in the same cycle as the ballot bits.
- Counter width is $clog2(WINDOW_CYCLES+1). No wrap-around: the counter is only reloaded on entry to OPEN.

## Timing
- Reset values: A–E=0, voted=0, yes_cnt=0, busy=0, valid=0, state=IDLE. Synchronizer, debouncer and counter registers are cleared.
- Reset asserted mid-session aborts the session immediately. No valid is produced.
- start sampled high at edge N: busy=1 from N+1.
- With no early close, OPEN lasts exactly WINDOW_CYCLES cycles, DONE (valid=1) is the following cycle, and busy falls as valid rises.
- Early close: the cycle after the fifth ballot bit is set is DONE.
- Pin-to-ballot latency: 2 (sync) + DEB_CYCLES (debounce) + 1 (edge/latch) cycles. Without debounce it is 3 cycles.
- A press edge in the last OPEN cycle is counted. One arriving in DONE is not.
- Simultaneous presses by several voters in one cycle are all latched.

## Configuration
- VOTE_COLLECTOR_DEBOUNCE_EN defined: a per-button counter debouncer is inserted after the synchronizer. The conditioned level changes only after DEB_CYCLES consecutive cycles at the new synchronized value.
- Undefined: the debouncer is removed, the synchronized level feeds the edge detector directly, and DEB_CYCLES is unused.

## Structure
- Shared package vote_pkg:
  - state enum (IDLE, OPEN, DONE, HOLD)
  - NUM_VOTERS=5
  - yes-count width constant
- Sub-module vote_debounce: one instance per button, containing the synchronizer, debouncer (macro-guarded) and edge detector. It outputs a level and a press pulse.

## Test plan
- Reset: hold rst_n=0 while toggling vote_btn and start → all outputs 0. Release with no start → stays IDLE, no valid.
- Normal session, WINDOW_CYCLES=50: press A, C, D once each → one valid pulse 50 cycles after busy rises. A,B,C,D,E=1,0,1,1,0, yes_cnt=3, voted=5'b01101.
- Early close: all five press within the window → DONE the cycle after the last latch, valid=1, yes_cnt=5, busy low well before 50 cycles.
- Bounce, debounce enabled, DEB_CYCLES=16: 10-cycle glitch pulses on B → no vote. Then a clean 30-cycle press → B=1 after 19 cycles. Re-press B → no change.
- Start misuse: start pulses during OPEN → window is not restarted. Button held through start → not counted until released and re-pressed.
- Reset mid-OPEN after two votes → outputs return to 0, no valid pulse. A new start runs a clean session.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared definitions for the vote_collector block.
//   NUM_VOTERS   : number of voter buttons / ballot bits
//   YES_CNT_W    : width of the registered yes-count
//   vote_state_e : session FSM states
//   popcount()   : yes-count of a ballot vector
package vote_pkg;

  localparam int unsigned NUM_VOTERS = 5;
  localparam int unsigned YES_CNT_W  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StOpen,
    StDone,
    StHold
  } vote_state_e;

  function automatic logic [YES_CNT_W-1:0] popcount(input logic [NUM_VOTERS-1:0] v);
    logic [YES_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      c = c + {{(YES_CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/vote_debounce.sv
// Per-button input conditioning: 2-flop synchronizer, optional counter debouncer, and
// rising-edge detector.
// Optional feature macro: VOTE_COLLECTOR_DEBOUNCE_EN (inserts the debouncer).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   btn   : raw asynchronous button, 1 = pressed
//   level : conditioned button level
//   press : one-cycle pulse on a 0->1 transition of level
module vote_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  if (DEB_CYCLES < 2) begin : gen_bad_deb_cycles
    $error("vote_debounce: DEB_CYCLES must be >= 2");
  end

  logic sync1_q, sync2_q;
  logic level_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef VOTE_COLLECTOR_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEB_CYCLES);

  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic            deb_level_q, deb_level_d;

  // Counts consecutive cycles where the synchronized value differs from the held level;
  // the level flips on the DEB_CYCLES-th such cycle.
  always_comb begin
    deb_cnt_d   = deb_cnt_q;
    deb_level_d = deb_level_q;
    if (sync2_q == deb_level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DebW'(DEB_CYCLES - 1)) begin
      deb_cnt_d   = '0;
      deb_level_d = sync2_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q   <= '0;
      deb_level_q <= 1'b0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      deb_level_q <= deb_level_d;
    end
  end

  assign level = deb_level_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= level;
    end
  end

  assign press = level & ~level_prev_q;

endmodule

// File: rtl/vote_collector.sv
// Voting-session front-end for the five-input majority stage. Conditions five voter
// buttons, runs a timed session, latches at most one "yes" per voter and presents the
// final ballot on A..E with a one-cycle valid strobe and a yes-count.
// Optional feature macro: VOTE_COLLECTOR_DEBOUNCE_EN (per-button debouncer).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : opens a session from IDLE or HOLD
//   vote_btn   : raw voter buttons, bit 0 -> A ... bit 4 -> E
//   A..E       : latched ballot bits
//   voted      : per-voter has-voted flags
//   yes_cnt    : population count of the ballot
//   busy       : high while the session is open
//   valid      : one-cycle pulse when the ballot is final
module vote_collector
  import vote_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 16,
  parameter int unsigned WINDOW_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_VOTERS-1:0] vote_btn,
  output logic                  A,
  output logic                  B,
  output logic                  C,
  output logic                  D,
  output logic                  E,
  output logic [NUM_VOTERS-1:0] voted,
  output logic [YES_CNT_W-1:0]  yes_cnt,
  output logic                  busy,
  output logic                  valid
);

  localparam int unsigned CntW = $clog2(WINDOW_CYCLES + 1);

  if (WINDOW_CYCLES < 1) begin : gen_bad_window
    $error("vote_collector: WINDOW_CYCLES must be >= 1");
  end

  logic [NUM_VOTERS-1:0] btn_level, btn_press, new_vote;

  for (genvar i = 0; i < NUM_VOTERS; i++) begin : gen_btn
    vote_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_vote_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (vote_btn[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  vote_state_e           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NUM_VOTERS-1:0] ballot_q, ballot_d;
  logic [NUM_VOTERS-1:0] voted_q, voted_d;
  logic [YES_CNT_W-1:0]  yes_cnt_q, yes_cnt_d;

  // First press edge per voter only.
  assign new_vote = btn_press & btn_level & ~voted_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ballot_d = ballot_q;
    voted_d  = voted_q;
    unique case (state_q)
      StIdle, StHold: begin
        if (start) begin
          state_d  = StOpen;
          cnt_d    = CntW'(WINDOW_CYCLES);
          ballot_d = '0;
          voted_d  = '0;
        end
      end
      StOpen: begin
        cnt_d    = cnt_q - 1'b1;
        ballot_d = ballot_q | new_vote;
        voted_d  = voted_q | new_vote;
        if (cnt_q == CntW'(1) || (&voted_d)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StHold;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    yes_cnt_d = popcount(ballot_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ballot_q  <= '0;
      voted_q   <= '0;
      yes_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ballot_q  <= ballot_d;
      voted_q   <= voted_d;
      yes_cnt_q <= yes_cnt_d;
    end
  end

  assign A       = ballot_q[0];
  assign B       = ballot_q[1];
  assign C       = ballot_q[2];
  assign D       = ballot_q[3];
  assign E       = ballot_q[4];
  assign voted   = voted_q;
  assign yes_cnt = yes_cnt_q;
  assign busy    = (state_q == StOpen);
  assign valid   = (state_q == StDone);

endmodule

// File: tb/tb_vote_collector.sv
// Self-checking bench for vote_collector: sessions push their expected final ballot
// into a queue; a monitor pops and compares on every valid pulse.
module tb_vote_collector;

  localparam int unsigned DEB = 16;
  localparam int unsigned WIN = 50;
`ifdef VOTE_COLLECTOR_DEBOUNCE_EN
  localparam int unsigned LAT = 3 + DEB;
`else
  localparam int unsigned LAT = 3;
`endif
  localparam int unsigned HOLD_CYC = LAT + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] vote_btn = '0;
  logic       A, B, C, D, E;
  logic [4:0] voted;
  logic [2:0] yes_cnt;
  logic       busy, valid;

  vote_collector #(
    .DEB_CYCLES   (DEB),
    .WINDOW_CYCLES(WIN)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .vote_btn(vote_btn),
    .A       (A),
    .B       (B),
    .C       (C),
    .D       (D),
    .E       (E),
    .voted   (voted),
    .yes_cnt (yes_cnt),
    .busy    (busy),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ballot;
    logic [2:0]  cnt;
    int unsigned len;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] all_outs();
    return {A, B, C, D, E, voted, yes_cnt, busy, valid};
  endfunction

  // Monitor: busy-length counter and ballot comparison at each valid pulse.
  initial begin
    int unsigned len = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: valid seen with no session expected");
        end else begin
          e = exp_q.pop_front();
          check("valid_ballot", {27'd0, E, D, C, B, A}, {27'd0, e.ballot});
          check("valid_voted", {27'd0, voted}, {27'd0, e.ballot});
          check("valid_yes_cnt", {29'd0, yes_cnt}, {29'd0, e.cnt});
          check("open_length", len, e.len);
          check("busy_low_at_valid", {31'd0, busy}, 32'd0);
        end
        len = 0;
      end else if (busy) begin
        len++;
      end else begin
        len = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves start sampled at the edge just passed; the FSM is OPEN afterwards.
  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 300 && !valid; k++) @(negedge clk);
    if (!valid) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout waiting for valid, got 0 expected 1", name);
    end
    cyc(1);
  endtask

  initial begin
    // Reset with activity on the inputs.
    for (int i = 0; i < 8; i++) begin
      vote_btn = 5'(i * 7);
      start    = i[0];
      @(negedge clk);
      check("reset_outputs", {17'd0, all_outs()}, 32'd0);
    end
    vote_btn = '0;
    start    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(10);
    check("idle_after_reset", {17'd0, all_outs()}, 32'd0);

    // Normal session: A, C, D vote; full window.
    exp_q.push_back('{ballot: 5'b01101, cnt: 3'd3, len: WIN});
    do_start();
    vote_btn[0] = 1'b1;
    cyc(2);
    vote_btn[2] = 1'b1;
    cyc(2);
    vote_btn[3] = 1'b1;
    cyc(HOLD_CYC);
    vote_btn = '0;
    wait_valid("session_normal");
    cyc(3);
    check("hold_ballot", {27'd0, E, D, C, B, A}, 32'h0d);
    check("hold_yes_cnt", {29'd0, yes_cnt}, 32'd3);
    check("hold_busy", {31'd0, busy}, 32'd0);
    // Press during HOLD is discarded.
    vote_btn[4] = 1'b1;
    cyc(HOLD_CYC);
    vote_btn = '0;
    cyc(HOLD_CYC);
    check("hold_press_ignored", {27'd0, voted}, 32'h0d);

    // Early close: all five simultaneously.
    exp_q.push_back('{ballot: 5'b11111, cnt: 3'd5, len: LAT});
    do_start();
    vote_btn = 5'b11111;
    wait_valid("session_early");
    vote_btn = '0;
    cyc(HOLD_CYC);

    // Bounce / latency on B.
    exp_q.push_back('{ballot: 5'b00010, cnt: 3'd1, len: WIN});
    do_start();
`ifdef VOTE_COLLECTOR_DEBOUNCE_EN
    repeat (2) begin
      vote_btn[1] = 1'b1;
      cyc(10);
      vote_btn[1] = 1'b0;
      cyc(2);
    end
    check("glitch_no_vote", {27'd0, voted}, 32'd0);
`endif
    vote_btn[1] = 1'b1;
    cyc(LAT - 1);
    check("b_before_latency", {31'd0, B}, 32'd0);
    cyc(1);
    check("b_at_latency", {31'd0, B}, 32'd1);
`ifndef VOTE_COLLECTOR_DEBOUNCE_EN
    vote_btn[1] = 1'b0;
    cyc(4);
    vote_btn[1] = 1'b1;
    cyc(4);
    vote_btn[1] = 1'b0;
    cyc(2);
    check("repress_ignored", {27'd0, voted, yes_cnt}, {27'd0, 5'b00010, 3'd1});
`endif
    wait_valid("session_bounce");
    vote_btn = '0;
    cyc(HOLD_CYC);

    // Start misuse: C held through start, extra start during OPEN.
    vote_btn[2] = 1'b1;
    cyc(HOLD_CYC);
    exp_q.push_back('{ballot: 5'b00100, cnt: 3'd1, len: WIN});
    do_start();
    cyc(2);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    check("held_not_counted", {27'd0, voted}, 32'd0);
    vote_btn[2] = 1'b0;
    cyc(HOLD_CYC);
    check("released_not_counted", {27'd0, voted}, 32'd0);
    vote_btn[2] = 1'b1;
    cyc(LAT + 1);
    check("repress_counted", {27'd0, voted}, 32'h04);
    wait_valid("session_misuse");
    vote_btn = '0;
    cyc(HOLD_CYC);

    // Reset mid-OPEN after two votes: no valid expected.
    do_start();
    vote_btn = 5'b00011;
    cyc(LAT + 1);
    check("two_votes_before_reset", {27'd0, voted}, 32'h03);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {17'd0, all_outs()}, 32'd0);
    vote_btn = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(WIN + 10);
    check("after_abort_idle", {17'd0, all_outs()}, 32'd0);

    // Clean session after reset: E only.
    exp_q.push_back('{ballot: 5'b10000, cnt: 3'd1, len: WIN});
    do_start();
    vote_btn[4] = 1'b1;
    cyc(HOLD_CYC);
    vote_btn = '0;
    wait_valid("session_after_reset");
    cyc(5);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
